online_div_seq: RTL and testbench
=================================

// Module: online_div_seq
// PURPOSE
//  Frame sequencer for the combinational online_divider_2D array: collects MSD-first
//  signed-digit streams x and d one digit pair per cycle, holds the array inputs stable
//  for DIV_LAT settle cycles, registers q, then streams q MSD-first. Valid/ready on both
//  sides; one frame in flight, no overlap of load and drain.
// PARAMETERS
//  WIDTH    16  digits per frame (index 0 = integer digit, weight 2^-i)
//  P        16  precision passed to online_divider_2D
//  DIV_LAT   2  settle cycles allowed for the array before capture (>=1)
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  x_dig/d_dig valid
//  in_ready   out  1  sequencer accepts a digit pair this cycle
//  x_dig      in   2  dividend digit (signed_digit: 10=+1, 01=-1, 00/11=0)
//  d_dig      in   2  divisor digit, same encoding
//  out_valid  out  1  q_dig valid
//  out_ready  in   1  consumer takes q_dig this cycle
//  q_dig      out  2  quotient digit, MSD (index 0) first
//  out_last   out  1  high with out_valid on digit WIDTH-1
//  busy       out  1  state != IDLE
//  norm_err   out  1  sticky: divisor of current frame not normalised
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, x/d/q buffers zeroed; in_ready=1, out_valid=0,
//   q_dig=00, out_last=0, busy=0, norm_err=0. Reset mid-frame discards all data.
//  Handshake: transfer on valid&&ready at rising edge; out_valid, q_dig and out_last held
//   unchanged while out_valid&&!out_ready. in_ready is 0 in EVAL and DRAIN.
//  IDLE: in_ready=1; accept -> store digit 0 at idx 0, clear norm_err, idx=1, -> LOAD.
//  LOAD: in_ready=1; each accept stores x[idx],d[idx], idx++; gaps (in_valid=0) allowed.
//   Accept at idx==WIDTH-1 -> EVAL, settle counter=0.
//  EVAL: buffers drive the divider unchanged; counter increments each cycle; at
//   counter==DIV_LAT-1 capture q into q_reg, evaluate normalisation, idx=0, -> DRAIN.
//   First out_valid appears DIV_LAT+1 cycles after the last input accept.
//  Normalisation: d[0]==0 and d[1]==+1 (10) required. Otherwise norm_err=1 and q_reg is
//   forced all zero; frame still drains WIDTH beats. norm_err holds until next frame's
//   first accept or reset.
//  DRAIN: out_valid=1, q_dig=q_reg[idx], out_last=(idx==WIDTH-1); accept -> idx++;
//   accept of the last digit -> IDLE, idx=0, so in_ready rises the next cycle.
//  idx is $clog2(WIDTH) bits; never wraps inside a frame; no other path back to IDLE.
//  Digit 11 is treated as zero by the array; no error is raised for it.
// STRUCTURE
//  rbr_pkg: existing signed_digit; add SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00 and
//   typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_EVAL, SEQ_DRAIN} div_seq_state_t.
//  One sub-module: online_divider_2D #(.WIDTH(WIDTH), .P(P)) fed from x/d buffers.
//  FSM, index counter, settle counter and q_reg live in this module.
// TESTING
//  1 x=[0,0,+1 x14], d=[0,+1 x15], no stalls -> 16 beats, out_last on beat 16 only;
//    q value within 2^-14 of x/d (~0.49998); first out_valid DIV_LAT+1 cycles after last accept.
//  2 Same frame, out_ready pattern 1,0,1,0... -> q_dig/out_last stable during stalls;
//    exactly 16 distinct beats, identical digits to test 1.
//  3 Same frame, in_valid randomly low 50% -> same q digits as test 1; in_ready=0
//    throughout EVAL/DRAIN while in_valid is held high.
//  4 d=[0,0,+1 x14] -> norm_err=1 at the first out_valid; 16 beats all 00; next valid
//    frame clears norm_err at its first accept.
//  5 rst after 7 input accepts, and again after 3 output beats -> next cycle
//    in_ready=1, out_valid=0, busy=0; following test-1 frame gives test-1 result.
//  6 Two back-to-back test-1 frames, in_valid always 1 -> in_ready=1 exactly one
//    cycle after the out_last handshake; both frames give the correct result.

Source files
------------

// File: rtl/rbr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rbr_pkg                                                              |
// | Shared redundant-binary types: signed digits and sequencer states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rbr_pkg;

  typedef logic [1:0] signed_digit;

  localparam signed_digit SD_POS  = 2'b10;
  localparam signed_digit SD_NEG  = 2'b01;
  localparam signed_digit SD_ZERO = 2'b00;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_EVAL, SEQ_DRAIN} div_seq_state_t;

  // Numeric value of a digit; the unused code 11 reads as zero.
  function automatic logic signed [1:0] sd_val(input signed_digit s);
    case (s)
      SD_POS:  return 2'sd1;
      SD_NEG:  return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/online_divider_2D.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | online_divider_2D                                                    |
// | Combinational divider array: signed-digit x and d (digit i has       |
// | weight 2^-i) in, signed-digit quotient q out, truncated toward zero  |
// | and saturated at magnitude just below 2.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module online_divider_2D
  import rbr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int P     = 16
) (
  input  signed_digit [WIDTH-1:0] x,
  input  signed_digit [WIDTH-1:0] d,
  output signed_digit [WIDTH-1:0] q
);

  localparam int NW = 2 * WIDTH - 1;

  logic signed [WIDTH+1:0] w_xv;
  logic signed [WIDTH+1:0] w_dv;
  logic signed [WIDTH+1:0] w_wt;
  logic [WIDTH-1:0]        w_xm;
  logic [WIDTH-1:0]        w_dm;
  logic [WIDTH-1:0]        w_mag;
  logic [NW-1:0]           w_num;
  logic [NW-1:0]           w_quo;
  logic [WIDTH:0]          w_rem;
  logic                    w_neg;

  // Digit vectors to two's complement, restoring-division array, back to digits.
  always_comb begin
    w_xv  = '0;
    w_dv  = '0;
    w_wt  = '0;
    w_rem = '0;
    w_quo = '0;
    q     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_wt = (WIDTH+2)'(1) << (WIDTH - 1 - i);
      if (x[i] == SD_POS)      w_xv = w_xv + w_wt;
      else if (x[i] == SD_NEG) w_xv = w_xv - w_wt;
      if (d[i] == SD_POS)      w_dv = w_dv + w_wt;
      else if (d[i] == SD_NEG) w_dv = w_dv - w_wt;
    end
    w_xm  = WIDTH'(w_xv[WIDTH+1] ? -w_xv : w_xv);
    w_dm  = WIDTH'(w_dv[WIDTH+1] ? -w_dv : w_dv);
    w_neg = w_xv[WIDTH+1] ^ w_dv[WIDTH+1];
    // Numerator scaled so the quotient lands in units of 2^-(WIDTH-1).
    w_num = {w_xm, (WIDTH-1)'(0)};
    for (int i = NW - 1; i >= 0; i--) begin
      w_rem = {w_rem[WIDTH-1:0], w_num[i]};
      if (w_rem >= {1'b0, w_dm}) begin
        w_rem    = w_rem - {1'b0, w_dm};
        w_quo[i] = 1'b1;
      end
    end
    // A zero divisor also lands here, so the result is never undefined.
    w_mag = (|w_quo[NW-1:WIDTH]) ? '1 : w_quo[WIDTH-1:0];
    for (int i = 0; i < WIDTH; i++) begin
      if (i < P && w_mag[WIDTH-1-i]) q[i] = w_neg ? SD_NEG : SD_POS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/online_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | online_div_seq                                                       |
// | Frame sequencer around online_divider_2D: loads x/d digit streams,   |
// | waits for the array to settle, captures q and streams it MSD-first.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module online_div_seq
  import rbr_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int P       = 16,
  parameter int DIV_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] x_dig,
  input  logic [1:0] d_dig,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] q_dig,
  output logic       out_last,
  output logic       busy,
  output logic       norm_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_LAT - 1);

  div_seq_state_t           r_state;
  logic [IW-1:0]            r_idx;
  logic [CW-1:0]            r_cnt;
  signed_digit [WIDTH-1:0]  r_x;
  signed_digit [WIDTH-1:0]  r_d;
  signed_digit [WIDTH-1:0]  r_q;
  signed_digit [WIDTH-1:0]  w_q;
  logic [IW-1:0]            w_idx_inc;
  logic                     w_norm_ok;

  online_divider_2D #(.WIDTH(WIDTH), .P(P)) u_div (
    .x (r_x),
    .d (r_d),
    .q (w_q)
  );

  assign w_idx_inc = r_idx + 1'b1;
  // Divisor must look like 0.1xxx so the quotient stays in range.
  assign w_norm_ok = (sd_val(r_d[0]) == 2'sd0) && (r_d[1] == SD_POS);

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SEQ_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_d       <= '0;
      r_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q_dig     <= SD_ZERO;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      norm_err  <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (in_valid) begin
            r_x[r_idx] <= x_dig;
            r_d[r_idx] <= d_dig;
            norm_err   <= 1'b0;
            busy       <= 1'b1;
            r_idx      <= IW'(1);
            r_state    <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          if (in_valid) begin
            r_x[r_idx] <= x_dig;
            r_d[r_idx] <= d_dig;
            if (r_idx == IDX_LAST) begin
              in_ready <= 1'b0;
              r_cnt    <= '0;
              r_state  <= SEQ_EVAL;
            end else begin
              r_idx <= w_idx_inc;
            end
          end
        end
        SEQ_EVAL: begin
          if (r_cnt == CNT_LAST) begin
            r_q      <= w_norm_ok ? w_q : '0;
            norm_err <= ~w_norm_ok;
            r_idx    <= '0;
            r_state  <= SEQ_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SEQ_DRAIN: begin
          if (!out_valid) begin
            // First drain cycle presents digit 0.
            out_valid <= 1'b1;
            q_dig     <= r_q[r_idx];
            out_last  <= (r_idx == IDX_LAST);
          end else if (out_ready) begin
            if (r_idx == IDX_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              q_dig     <= SD_ZERO;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              r_idx     <= '0;
              r_state   <= SEQ_IDLE;
            end else begin
              r_idx    <= w_idx_inc;
              q_dig    <= r_q[w_idx_inc];
              out_last <= (w_idx_inc == IDX_LAST);
            end
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_online_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_online_div_seq                                                    |
// | Self-checking bench: vector table, corner sequences, random frames.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_online_div_seq;
  import rbr_pkg::*;

  localparam int WIDTH   = 16;
  localparam int P       = 16;
  localparam int DIV_LAT = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, busy, norm_err;
  logic [1:0] x_dig, d_dig, q_dig;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit tx_done = 1'b0;

  online_div_seq #(.WIDTH(WIDTH), .P(P), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_dig(x_dig), .d_dig(d_dig), .out_valid(out_valid), .out_ready(out_ready),
    .q_dig(q_dig), .out_last(out_last), .busy(busy), .norm_err(norm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] x;
    logic [31:0] d;
    longint      exp_q;   // quotient in units of 2^-15
    int          exp_err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fr(input string s);
    logic [31:0] f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == "+")      f[2*i +: 2] = 2'b10;
      else if (s[i] == "-") f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  // Value of a digit frame in units of 2^-15.
  function automatic longint val(input logic [31:0] v);
    longint r = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[2*i +: 2] == 2'b10)      r += longint'(1) << (WIDTH - 1 - i);
      else if (v[2*i +: 2] == 2'b01) r -= longint'(1) << (WIDTH - 1 - i);
    end
    return r;
  endfunction

  function automatic longint labs(input longint a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic send(input logic [31:0] xf, input logic [31:0] df, input int n,
                      input int gap, input bit hold);
    int i = 0;
    int g = 0;
    bit first_pending = 1'b0;
    tx_done = 1'b0;
    while (i < n && g < 4000) begin
      @(negedge clk);
      g++;
      if (first_pending) begin
        chk("norm_err_clear", norm_err, 0);
        first_pending = 1'b0;
      end
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        x_dig    = xf[2*i +: 2];
        d_dig    = df[2*i +: 2];
      end
      if (in_valid && in_ready) begin
        if (i == 0) first_pending = 1'b1;
        if (i == WIDTH - 1) last_acc = cyc + 1;
        i++;
      end
    end
    if (i < n) chk("send_timeout", i, n);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    tx_done = 1'b1;
  endtask

  task automatic recv(output logic [31:0] q, input int n, input int mode,
                      input bit chk_ir, input int exp_err);
    int k = 0;
    int g = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    logic [1:0] hq = '0;
    logic hl = 1'b0;
    q = '0;
    while (k < n && g < 4000) begin
      @(negedge clk);
      g++;
      if (stalled) begin
        chk("hold_q", q_dig, hq);
        chk("hold_last", out_last, hl);
        chk("hold_valid", out_valid, 1);
      end
      if (chk_ir && tx_done) chk("in_ready_low", in_ready, 0);
      case (mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(99) < 60);
        default: out_ready = 1'b1;
      endcase
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("latency", cyc - last_acc, DIV_LAT + 1);
        if (exp_err >= 0) chk("norm_err_first", norm_err, exp_err);
      end
      stalled = out_valid && !out_ready;
      hq = q_dig;
      hl = out_last;
      if (out_valid && out_ready) begin
        q[2*k +: 2] = q_dig;
        chk("out_last", out_last, (k == WIDTH - 1));
        if (k == WIDTH - 1) chk("in_ready_pre", in_ready, 0);
        k++;
      end
    end
    if (k < n) chk("recv_timeout", k, n);
    if (k == WIDTH) begin
      @(negedge clk);
      chk("in_ready_rise", in_ready, 1);
      chk("busy_end", busy, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_norm_err", norm_err, 0);
    chk("rst_q_dig", q_dig, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
  endtask

  vec_t        tbl[7];
  logic [31:0] q1, q, qb, rx, rd;
  logic [31:0] t1x, t1d;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_dig = '0; d_dig = '0;
    tbl[0] = '{fr("00++++++++++++++"), fr("0+++++++++++++++"), 16383, 0};
    tbl[1] = '{fr("00++++++++++++++"), fr("00++++++++++++++"), 0, 1};
    tbl[2] = '{fr("00+0000000000000"), fr("0+00000000000000"), 16384, 0};
    tbl[3] = '{fr("00-0000000000000"), fr("0+00000000000000"), -16384, 0};
    tbl[4] = '{fr("0+00000000000000"), fr("0++0000000000000"), 21845, 0};
    tbl[5] = '{fr("0-00000000000000"), fr("0++-000000000000"), -26214, 0};
    tbl[6] = '{fr("00+0000000000000"), fr("+-00000000000000"), 0, 1};
    t1x = tbl[0].x;
    t1d = tbl[0].d;
    q1  = '0;

    do_reset();

    // Vector table, no stalls; includes the unnormalised-divisor cases.
    for (int v = 0; v < 7; v++) begin
      if (v > 0) begin
        @(negedge clk);
        chk("norm_err_sticky", norm_err, tbl[v-1].exp_err);
      end
      fork
        send(tbl[v].x, tbl[v].d, WIDTH, 0, 1'b0);
        recv(q, WIDTH, 0, 1'b0, tbl[v].exp_err);
      join
      if (tbl[v].exp_err != 0) begin
        chk("q_zero", q, 0);
      end else begin
        chk("q_value", labs(val(q) - tbl[v].exp_q) <= 1, 1);
        chk("q_bound", labs(val(q) * val(tbl[v].d) - val(tbl[v].x) * 32768)
                       < 2 * labs(val(tbl[v].d)), 1);
      end
      if (v == 0) q1 = q;
    end

    // Output stalls 1,0,1,0...
    out_ready = 1'b0;
    fork
      send(t1x, t1d, WIDTH, 0, 1'b0);
      recv(q, WIDTH, 1, 1'b0, 0);
    join
    chk("stall_digits", q, q1);

    // Input gaps, then in_valid held high through EVAL/DRAIN.
    fork
      send(t1x, t1d, WIDTH, 50, 1'b1);
      recv(q, WIDTH, 0, 1'b1, 0);
    join
    in_valid = 1'b0;
    chk("gap_digits", q, q1);

    // Reset in the middle of loading.
    send(t1x, t1d, 7, 0, 1'b0);
    do_reset();
    fork
      send(t1x, t1d, WIDTH, 0, 1'b0);
      recv(q, WIDTH, 0, 1'b0, 0);
    join
    chk("rst_load_digits", q, q1);

    // Reset in the middle of draining.
    fork
      send(t1x, t1d, WIDTH, 0, 1'b0);
      recv(q, 3, 0, 1'b0, 0);
    join
    do_reset();
    fork
      send(t1x, t1d, WIDTH, 0, 1'b0);
      recv(q, WIDTH, 0, 1'b0, 0);
    join
    chk("rst_drain_digits", q, q1);

    // Back-to-back frames with in_valid always high.
    fork
      begin
        send(t1x, t1d, WIDTH, 0, 1'b1);
        send(t1x, t1d, WIDTH, 0, 1'b0);
      end
      begin
        recv(q, WIDTH, 0, 1'b0, 0);
        recv(qb, WIDTH, 0, 1'b0, 0);
      end
    join
    chk("b2b_first", q, q1);
    chk("b2b_second", qb, q1);

    // Random frames against the arithmetic reference.
    for (int r = 0; r < 30; r++) begin
      bit     bad;
      longint dv, xv;
      int     tries;
      rd = '0;
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < WIDTH; i++) rd[2*i +: 2] = 2'($urandom_range(3));
      end else begin
        rd[3:2] = 2'b10;
        for (int i = 2; i < WIDTH; i++) rd[2*i +: 2] = 2'($urandom_range(3));
      end
      bad = !((rd[1:0] == 2'b00 || rd[1:0] == 2'b11) && rd[3:2] == 2'b10);
      dv  = val(rd);
      tries = 0;
      do begin
        rx = '0;
        for (int i = 1; i < WIDTH; i++) rx[2*i +: 2] = 2'($urandom_range(3));
        xv = val(rx);
        tries++;
        if (tries > 20) begin
          rx = '0;
          xv = 0;
        end
      end while (!bad && labs(xv) >= dv);
      fork
        send(rx, rd, WIDTH, 30, 1'b0);
        recv(q, WIDTH, 2, 1'b0, bad ? 1 : 0);
      join
      if (bad) chk("rand_zero", q, 0);
      else     chk("rand_bound", labs(val(q) * dv - xv * 32768) < 2 * dv, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
